// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - state encoding shared by x_input_conditioner and two_bit_counter
package counter_pkg;

   localparam logic [1:0] ST_STABLE_LO = 2'd0;
   localparam logic [1:0] ST_WAIT_HI   = 2'd1;
   localparam logic [1:0] ST_STABLE_HI = 2'd2;
   localparam logic [1:0] ST_WAIT_LO   = 2'd3;

   localparam int STABLE_CYCLES_DEFAULT = 4;

   typedef enum logic [1:0] {
      STABLE_LO = ST_STABLE_LO,
      WAIT_HI   = ST_WAIT_HI,
      STABLE_HI = ST_STABLE_HI,
      WAIT_LO   = ST_WAIT_LO
   } cond_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with synchronous active-high reset
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/x_input_conditioner.sv
// rtl/x_input_conditioner.sv - synchronize and debounce raw x, emit rise/fall pulses
module x_input_conditioner
   import counter_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
   parameter int CNT_WIDTH     = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic x_raw,
   output logic x,
   output logic x_rise,
   output logic x_fall,
   output logic busy
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic                 s2;
   cond_state_t          state;
   logic [CNT_WIDTH-1:0] cnt;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (x_raw),
      .q     (s2)
   );

   // busy is assigned alongside every state change so it always matches the new state
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= STABLE_LO;
         cnt    <= '0;
         x      <= 1'b0;
         x_rise <= 1'b0;
         x_fall <= 1'b0;
         busy   <= 1'b0;
      end else begin
         x_rise <= 1'b0;
         x_fall <= 1'b0;
         case (state)
            STABLE_LO: begin
               if (s2) begin
                  state <= WAIT_HI;
                  cnt   <= CNT_ONE;
                  busy  <= 1'b1;
               end else begin
                  cnt   <= '0;
               end
            end
            WAIT_HI: begin
               if (!s2) begin
                  state <= STABLE_LO;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state  <= STABLE_HI;
                  cnt    <= '0;
                  x      <= 1'b1;
                  x_rise <= 1'b1;
                  busy   <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            STABLE_HI: begin
               if (!s2) begin
                  state <= WAIT_LO;
                  cnt   <= CNT_ONE;
                  busy  <= 1'b1;
               end else begin
                  cnt   <= '0;
               end
            end
            WAIT_LO: begin
               if (s2) begin
                  state <= STABLE_HI;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state  <= STABLE_LO;
                  cnt    <= '0;
                  x      <= 1'b0;
                  x_fall <= 1'b1;
                  busy   <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= STABLE_LO;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
